// File: rtl/apb_rr_master_if.sv
// Bundles the requester handshake and the APB3 bus of apb_rr_master.
// The master modport is the arbiter's view; slave is the requesters/APB slave side.
interface apb_rr_master_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int NUM_REQ    = 2
) ();

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_write;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ-1:0]            rsp_valid;
  logic [DATA_WIDTH-1:0]         rsp_rdata;
  logic                          rsp_err;

  logic                          psel;
  logic                          penable;
  logic                          pwrite;
  logic [ADDR_WIDTH-1:0]         paddr;
  logic [DATA_WIDTH-1:0]         pwdata;
  logic [DATA_WIDTH-1:0]         prdata;
  logic                          pready;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, prdata, pready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
           psel, penable, pwrite, paddr, pwdata
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, prdata, pready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
           psel, penable, pwrite, paddr, pwdata
  );

endinterface

// File: rtl/apb_rr_master.sv
// APB3 master shared by NUM_REQ requesters through a round-robin arbiter,
// with a bounded wait on pready and a one-cycle response pulse per transfer.
module apb_rr_master #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int NUM_REQ    = 2,
  parameter int TIMEOUT    = 16
) (
  input  logic             pclk,
  input  logic             presetn,
  apb_rr_master_if.master  bus
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_e;

  state_e                 state_q;
  logic [IDX_W-1:0]       grant_q;
  logic [CNT_W-1:0]       wait_cnt_q;
  logic                   psel_q;
  logic                   penable_q;
  logic                   pwrite_q;
  logic [ADDR_WIDTH-1:0]  paddr_q;
  logic [DATA_WIDTH-1:0]  pwdata_q;
  logic [NUM_REQ-1:0]     rsp_valid_q;
  logic [DATA_WIDTH-1:0]  rsp_rdata_q;
  logic                   rsp_err_q;

  logic [IDX_W-1:0]       grant_d;
  logic                   any_req;
  logic                   sel_write;
  logic [ADDR_WIDTH-1:0]  sel_addr;
  logic [DATA_WIDTH-1:0]  sel_wdata;

  // grant_q doubles as the round-robin pointer: the search starts just above it.
  function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W-1:0] base, input int off);
    int sum;
    sum = int'(base) + off;
    if (sum >= NUM_REQ) sum -= NUM_REQ;
    return IDX_W'(sum);
  endfunction

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    grant_d = grant_q;
    any_req = 1'b0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      if (!any_req && bus.req_valid[wrap_idx(grant_q, off)]) begin
        any_req = 1'b1;
        grant_d = wrap_idx(grant_q, off);
      end
    end
  end

  always_comb begin
    sel_write = bus.req_write[grant_d];
    sel_addr  = bus.req_addr[int'(grant_d)*ADDR_WIDTH +: ADDR_WIDTH];
    sel_wdata = bus.req_wdata[int'(grant_d)*DATA_WIDTH +: DATA_WIDTH];
  end

  always_comb begin
    bus.req_ready = '0;
    if (state_q == IDLE && any_req) bus.req_ready[grant_d] = 1'b1;
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q     <= IDLE;
      grant_q     <= IDX_W'(NUM_REQ-1);
      wait_cnt_q  <= '0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      rsp_valid_q <= '0;
      case (state_q)
        IDLE: begin
          if (any_req) begin
            grant_q  <= grant_d;
            pwrite_q <= sel_write;
            paddr_q  <= sel_addr;
            pwdata_q <= sel_wdata;
            psel_q   <= 1'b1;
            state_q  <= SETUP;
          end
        end
        SETUP: begin
          penable_q  <= 1'b1;
          wait_cnt_q <= '0;
          state_q    <= ACCESS;
        end
        ACCESS: begin
          if (bus.pready) begin
            psel_q               <= 1'b0;
            penable_q            <= 1'b0;
            rsp_valid_q[grant_q] <= 1'b1;
            rsp_rdata_q          <= pwrite_q ? '0 : bus.prdata;
            rsp_err_q            <= 1'b0;
            state_q              <= IDLE;
          end else if (wait_cnt_q == CNT_W'(TIMEOUT-1)) begin
            // Slave never answered: abort and report an error with no data.
            psel_q               <= 1'b0;
            penable_q            <= 1'b0;
            rsp_valid_q[grant_q] <= 1'b1;
            rsp_rdata_q          <= '0;
            rsp_err_q            <= 1'b1;
            state_q              <= IDLE;
          end else begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.psel      = psel_q;
  assign bus.penable   = penable_q;
  assign bus.pwrite    = pwrite_q;
  assign bus.paddr     = paddr_q;
  assign bus.pwdata    = pwdata_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;

endmodule
